// File: rtl/wt_store_wbuf.sv
// Write-through store buffer: in-order issue, same-word coalescing into the
// newest un-issued entry, out-of-order ack with in-order retirement.
module wt_store_wbuf #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TID_W  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W-1:0]     req_data_i,
  input  logic [DATA_W/8-1:0]   req_be_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_data_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  output logic [TID_W-1:0]      mem_tid_o,
  input  logic                  ack_valid_i,
  input  logic [TID_W-1:0]      ack_tid_i,
  input  logic [ADDR_W-1:0]     chk_addr_i,
  output logic                  chk_hit_o,
  output logic                  empty_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BE_W - 1);

  // DONE = acked but waiting for older entries to retire first
  typedef enum logic [1:0] {S_FREE, S_PEND, S_INFL, S_DONE} ent_state_e;

  ent_state_e        state_q [DEPTH];
  ent_state_e        state_d [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [BE_W-1:0]   be_q    [DEPTH];
  logic [BE_W-1:0]   be_d    [DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d, iss_ptr_q, iss_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] req_waddr;
  logic [IDX_W-1:0]  newest, ack_idx;
  logic              merge_ok, has_room, do_merge, do_alloc;
  logic              issue_fire, ack_hit, retire;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  // Request classification and handshakes, all from registered state
  always_comb begin
    req_waddr  = req_addr_i & WORD_MASK;
    newest     = (wr_ptr_q == '0) ? IDX_W'(DEPTH - 1) : wr_ptr_q - IDX_W'(1);
    merge_ok   = (state_q[newest] == S_PEND) && (newest != iss_ptr_q) &&
                 (addr_q[newest] == req_waddr);
    has_room   = 32'(count_q) < DEPTH;
    do_merge   = req_valid_i && merge_ok;
    do_alloc   = req_valid_i && !merge_ok && has_room;
    issue_fire = mem_valid_o && mem_ready_i;
    ack_idx    = IDX_W'(ack_tid_i);
    ack_hit    = ack_valid_i && (32'(ack_tid_i) < DEPTH) && (state_q[ack_idx] == S_INFL);
    // an ack to the oldest entry retires it straight away
    retire     = (state_q[rd_ptr_q] == S_DONE) || (ack_hit && (ack_idx == rd_ptr_q));
  end

  // Next-state: merge/allocate, issue, ack, retire act on disjoint entries
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    wr_ptr_d  = wr_ptr_q;
    iss_ptr_d = iss_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (do_merge) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (req_be_i[b]) data_d[newest][8*b +: 8] = req_data_i[8*b +: 8];
      end
      be_d[newest] = be_q[newest] | req_be_i;
    end else if (do_alloc) begin
      state_d[wr_ptr_q] = S_PEND;
      addr_d[wr_ptr_q]  = req_waddr;
      data_d[wr_ptr_q]  = req_data_i;
      be_d[wr_ptr_q]    = req_be_i;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end

    if (issue_fire) begin
      state_d[iss_ptr_q] = S_INFL;
      iss_ptr_d          = ptr_inc(iss_ptr_q);
    end

    if (ack_hit) state_d[ack_idx] = S_DONE;

    if (retire) begin
      state_d[rd_ptr_q] = S_FREE;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end

    case ({do_alloc, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        state_q[i] <= S_FREE;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        be_q[i]    <= '0;
      end
      wr_ptr_q  <= '0;
      iss_ptr_q <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      wr_ptr_q  <= wr_ptr_d;
      iss_ptr_q <= iss_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Memory port driven from the issue entry; zeroed when nothing is offered
  always_comb begin
    req_ready_o = merge_ok || has_room;
    mem_valid_o = (state_q[iss_ptr_q] == S_PEND);
    mem_addr_o  = mem_valid_o ? addr_q[iss_ptr_q] : '0;
    mem_data_o  = mem_valid_o ? data_q[iss_ptr_q] : '0;
    mem_be_o    = mem_valid_o ? be_q[iss_ptr_q]   : '0;
    mem_tid_o   = mem_valid_o ? TID_W'(iss_ptr_q) : '0;
    empty_o     = (count_q == '0);
  end

  // Load-vs-pending-store word address check
  always_comb begin
    chk_hit_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((state_q[i] != S_FREE) && (addr_q[i] == (chk_addr_i & WORD_MASK))) chk_hit_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_wt_store_wbuf.sv
// Directed bench for wt_store_wbuf with a scoreboard on the memory port.
module tb_wt_store_wbuf;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_be;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_data;
  logic [3:0]  mem_be;
  logic [1:0]  mem_tid;
  logic        ack_valid;
  logic [1:0]  ack_tid;
  logic [31:0] chk_addr;
  logic        chk_hit, empty;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  tid;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  wt_store_wbuf #(.DEPTH(2), .ADDR_W(32), .DATA_W(32), .TID_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_be_i(req_be),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_be_o(mem_be), .mem_tid_o(mem_tid),
    .ack_valid_i(ack_valid), .ack_tid_i(ack_tid),
    .chk_addr_i(chk_addr), .chk_hit_o(chk_hit), .empty_o(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, want $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b[i]}};
    return m;
  endfunction

  // Scoreboard monitor: every accepted memory write must match the queue head
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mem_unexpected: got write addr 0x%0h tid %0d, want none", mem_addr, mem_tid);
      end else begin
        mon_e = exp_q.pop_front();
        check("mem_addr", 64'(mem_addr), 64'(mon_e.addr));
        check("mem_data", 64'(mem_data & be_mask(mon_e.be)), 64'(mon_e.data & be_mask(mon_e.be)));
        check("mem_be",   64'(mem_be),   64'(mon_e.be));
        check("mem_tid",  64'(mem_tid),  64'(mon_e.tid));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                      input logic [1:0] t);
    exp_t e;
    e.addr = a; e.data = d; e.be = b; e.tid = t;
    exp_q.push_back(e);
  endtask

  // Must be called just after a rising edge
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_addr = a; req_data = d; req_be = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    req_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got req_ready=0 for addr 0x%0h, want 1", a);
    end
  endtask

  task automatic ack(input logic [1:0] t);
    ack_valid = 1'b1;
    ack_tid   = t;
    tick();
    ack_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; mem_ready = 1'b0; ack_valid = 1'b0; ack_tid = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    check({tag, "_mem_data"},  64'(mem_data),  64'd0);
    check({tag, "_mem_be"},    64'(mem_be),    64'd0);
    check({tag, "_mem_tid"},   64'(mem_tid),   64'd0);
    check({tag, "_chk_hit"},   64'(chk_hit),   64'd0);
    check({tag, "_empty"},     64'(empty),     64'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_be = '0;
    mem_ready = 1'b0; ack_valid = 1'b0; ack_tid = '0; chk_addr = 32'h8000_0020;

    do_reset();
    @(negedge clk);
    chk_reset("por");

    // single store, issue one cycle after acceptance, ack empties the buffer
    tick();
    mem_ready = 1'b1;
    push(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 2'd0);
    send(32'h8000_0004, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    check("single_valid", 64'(mem_valid), 64'd1);
    check("single_tid",   64'(mem_tid),   64'd0);
    tick();
    check("single_not_empty", 64'(empty), 64'd0);
    ack(2'd0);
    @(negedge clk);
    check("single_empty", 64'(empty), 64'd1);

    // coalesce into entry 1 while entry 0 is held at the port
    do_reset();
    push(32'h8000_0040, 32'hA5A5_A5A5, 4'hF, 2'd0);
    send(32'h8000_0040, 32'hA5A5_A5A5, 4'hF);
    push(32'h8000_0010, 32'h3344_1122, 4'hF, 2'd1);
    send(32'h8000_0010, 32'h0000_1122, 4'h3);
    send(32'h8000_0010, 32'h3344_0000, 4'hC);
    @(negedge clk);
    check("coal_ready_merge", 64'(req_ready), 64'd1);
    req_addr = 32'h8000_0050;
    #1;
    check("coal_ready_full", 64'(req_ready), 64'd0);
    tick();
    mem_ready = 1'b1;
    wait_drain();
    ack(2'd0);
    ack(2'd1);
    @(negedge clk);
    check("coal_empty", 64'(empty), 64'd1);

    // full ring: third store waits for an ack on the oldest entry
    do_reset();
    push(32'h8000_0100, 32'h1111_1111, 4'hF, 2'd0);
    send(32'h8000_0100, 32'h1111_1111, 4'hF);
    push(32'h8000_0200, 32'h2222_2222, 4'hF, 2'd1);
    send(32'h8000_0200, 32'h2222_2222, 4'hF);
    req_valid = 1'b1; req_addr = 32'h8000_0300; req_data = 32'h3333_3333; req_be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_ready_low", 64'(req_ready), 64'd0);
    end
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    check("full_ready_infl", 64'(req_ready), 64'd0);
    tick();
    ack_valid = 1'b1; ack_tid = 2'd0;
    @(negedge clk);
    check("full_ready_ack_cycle", 64'(req_ready), 64'd0);
    tick();
    ack_valid = 1'b0;
    @(negedge clk);
    check("full_ready_after_ack", 64'(req_ready), 64'd1);
    push(32'h8000_0300, 32'h3333_3333, 4'hF, 2'd0);
    tick();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    wait_drain();
    ack(2'd1);
    ack(2'd0);
    @(negedge clk);
    check("full_empty", 64'(empty), 64'd1);

    // out-of-order ack: nothing retires until the oldest is acked
    do_reset();
    mem_ready = 1'b1;
    push(32'h8000_0400, 32'h4444_4444, 4'hF, 2'd0);
    send(32'h8000_0400, 32'h4444_4444, 4'hF);
    push(32'h8000_0404, 32'h5555_5555, 4'hF, 2'd1);
    send(32'h8000_0404, 32'h5555_5555, 4'hF);
    wait_drain();
    req_addr = 32'h8000_0500;
    ack(2'd3);
    @(negedge clk);
    check("ooo_bad_tid_ignored", 64'(req_ready), 64'd0);
    tick();
    ack(2'd1);
    @(negedge clk);
    check("ooo_no_retire_ready", 64'(req_ready), 64'd0);
    check("ooo_no_retire_empty", 64'(empty), 64'd0);
    tick();
    @(negedge clk);
    check("ooo_still_held", 64'(req_ready), 64'd0);
    ack(2'd0);
    @(negedge clk);
    check("ooo_first_retire_ready", 64'(req_ready), 64'd1);
    check("ooo_first_retire_empty", 64'(empty), 64'd0);
    tick();
    @(negedge clk);
    check("ooo_second_retire_empty", 64'(empty), 64'd1);

    // stability under back-pressure; same word to the issue entry allocates
    do_reset();
    push(32'h8000_0500, 32'hCAFE_F00D, 4'hF, 2'd0);
    send(32'h8000_0500, 32'hCAFE_F00D, 4'hF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stab_addr", 64'(mem_addr), 64'h8000_0500);
      check("stab_data", 64'(mem_data), 64'hCAFE_F00D);
      check("stab_be",   64'(mem_be),   64'hF);
      check("stab_tid",  64'(mem_tid),  64'd0);
    end
    tick();
    push(32'h8000_0500, 32'h0BAD_C0DE, 4'h1, 2'd1);
    send(32'h8000_0500, 32'h0BAD_C0DE, 4'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stab_addr", 64'(mem_addr), 64'h8000_0500);
      check("stab_data", 64'(mem_data), 64'hCAFE_F00D);
      check("stab_be",   64'(mem_be),   64'hF);
      check("stab_tid",  64'(mem_tid),  64'd0);
    end
    check("stab_ready_merge", 64'(req_ready), 64'd1);
    req_addr = 32'h8000_0600;
    #1;
    check("stab_ready_full", 64'(req_ready), 64'd0);
    tick();
    mem_ready = 1'b1;
    wait_drain();
    ack(2'd0);
    ack(2'd1);
    @(negedge clk);
    check("stab_empty", 64'(empty), 64'd1);

    // load address check, then reset in the middle of traffic
    do_reset();
    push(32'h8000_0020, 32'h1234_5678, 4'hF, 2'd0);
    send(32'h8000_0020, 32'h1234_5678, 4'hF);
    chk_addr = 32'h8000_0022;
    #1;
    check("chk_same_word", 64'(chk_hit), 64'd1);
    chk_addr = 32'h8000_0024;
    #1;
    check("chk_next_word", 64'(chk_hit), 64'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk_addr = 32'h8000_0020;
    #1;
    check("chk_inflight", 64'(chk_hit), 64'd1);
    tick();
    send(32'h8000_0030, 32'h9999_9999, 4'hF);
    @(negedge clk);
    check("pre_reset_valid", 64'(mem_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("mid_reset");
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
